i2c_eeprom_master: RTL and testbench

- Single-master I2C controller that issues byte-write and random-read transactions to an AT24Cxx-class serial EEPROM with an 8-bit word address.
- Sits between an Avalon-side command/response handshake and the open-drain SCL/SDA pads.
- It is the initiating end of the bus the EEPROM responds on: it generates START, repeated START and STOP, sends the control and address bytes, and checks ACKs.

---
 rtl/i2c_pkg.sv | 39 +++
 rtl/i2c_phase_timer.sv | 40 ++++
 rtl/i2c_eeprom_master.sv | 179 +++++++++++++++++
 tb/tb_i2c_eeprom_master.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C EEPROM master: FSM states, bus phases,
// control-byte fields and per-command symbol counts.
`timescale 1ns/1ps
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE,
      START,
      TX_BYTE,
      RX_ACK,
      RSTART,
      RX_BYTE,
      TX_NACK,
      STOP,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      P0,
      P1,
      P2,
      P3
   } phase_t;

   localparam logic [3:0] DEV_TYPE_DEF = 4'b1010;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   localparam int unsigned WR_SYMBOLS = 29;
   localparam int unsigned RD_SYMBOLS = 39;

   function automatic logic [7:0] ctrl_byte(input logic [3:0] dev_type,
                                            input logic [2:0] dev_sel,
                                            input logic       rw);
      return {dev_type, dev_sel, rw};
   endfunction

endpackage

// File: rtl/i2c_phase_timer.sv
// Quarter-bit phase generator: CLK_DIV clk cycles per phase, four phases per symbol.
`timescale 1ns/1ps
module i2c_phase_timer
   import i2c_pkg::*;
#(
   parameter int unsigned CLK_DIV = 125
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   clear,
   input  logic   enable,
   output logic   phase_tick,
   output phase_t phase,
   output logic   sample
);

   localparam int unsigned CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] div_cnt;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         div_cnt <= '0;
         phase   <= P0;
      end else if (enable) begin
         if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            phase   <= phase_t'(phase + 2'd1);
         end else begin
            div_cnt <= div_cnt + CW'(1);
         end
      end
   end

   assign phase_tick = enable && (div_cnt == DIV_LAST);
   // SDA is read at the very end of the SCL-high window
   assign sample     = phase_tick && (phase == P2);

endmodule

// File: rtl/i2c_eeprom_master.sv
// Single-master I2C controller issuing byte-write and random-read transactions
// to an 8-bit-address serial EEPROM; open-drain pad enables, no clock stretching.
`timescale 1ns/1ps
module i2c_eeprom_master
   import i2c_pkg::*;
#(
   parameter int unsigned CLK_DIV  = 125,
   parameter logic [3:0]  DEV_TYPE = DEV_TYPE_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_read,
   input  logic [2:0] cmd_dev_sel,
   input  logic [7:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic       rsp_nack,
   output logic [7:0] rsp_rdata,
   output logic       scl_oe,
   output logic       sda_oe,
   input  logic       sda_in
);

   state_t     state, state_next;
   phase_t     phase;
   logic       phase_tick, sample, sym_end;
   logic       tmr_clear;
   logic       accept;

   logic       is_read;
   logic [2:0] dev_sel;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic [7:0] tx_sh;
   logic [7:0] rx_sh;
   logic [2:0] bit_cnt;
   logic [1:0] byte_idx;
   logic       ack_nack;
   logic       sda_meta, sda_sync;

   assign tmr_clear = (state == IDLE) || (state == DONE);
   assign accept    = cmd_valid && cmd_ready;
   assign sym_end   = phase_tick && (phase == P3);

   i2c_phase_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .clear      (tmr_clear),
      .enable     (!tmr_clear),
      .phase_tick (phase_tick),
      .phase      (phase),
      .sample     (sample)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (cmd_valid) state_next = START;
         START:   if (sym_end) state_next = TX_BYTE;
         TX_BYTE: if (sym_end && bit_cnt == 3'd7) state_next = RX_ACK;
         RX_ACK: begin
            if (sym_end) begin
               if (ack_nack) begin
                  state_next = STOP;
               end else begin
                  case (byte_idx)
                     2'd0:    state_next = TX_BYTE;
                     2'd1:    state_next = is_read ? RSTART : TX_BYTE;
                     2'd2:    state_next = is_read ? RX_BYTE : STOP;
                     default: state_next = STOP;
                  endcase
               end
            end
         end
         RSTART:  if (sym_end) state_next = TX_BYTE;
         RX_BYTE: if (sym_end && bit_cnt == 3'd7) state_next = TX_NACK;
         TX_NACK: if (sym_end) state_next = STOP;
         STOP:    if (sym_end) state_next = DONE;
         DONE:    state_next = cmd_valid ? START : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      scl_oe    = 1'b0;
      sda_oe    = 1'b0;
      cmd_ready = (state == IDLE) || (state == DONE);
      rsp_valid = (state == DONE);
      case (state)
         START, RSTART: begin
            // Repeated START must hold SCL low in P0; a first START leaves it released
            scl_oe = ((phase == P0) && (state == RSTART)) || (phase == P3);
            sda_oe = (phase == P2) || (phase == P3);
         end
         TX_BYTE: begin
            scl_oe = (phase == P0) || (phase == P3);
            sda_oe = ~tx_sh[7];
         end
         RX_ACK, RX_BYTE, TX_NACK: begin
            scl_oe = (phase == P0) || (phase == P3);
         end
         STOP: begin
            scl_oe = (phase == P0);
            sda_oe = (phase == P0) || (phase == P1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sda_meta  <= 1'b1;
         sda_sync  <= 1'b1;
         is_read   <= 1'b0;
         dev_sel   <= '0;
         addr      <= '0;
         wdata     <= '0;
         tx_sh     <= '0;
         rx_sh     <= '0;
         bit_cnt   <= '0;
         byte_idx  <= '0;
         ack_nack  <= 1'b0;
         rsp_nack  <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         sda_meta <= sda_in;
         sda_sync <= sda_meta;

         if (accept) begin
            is_read  <= cmd_read;
            dev_sel  <= cmd_dev_sel;
            addr     <= cmd_addr;
            wdata    <= cmd_wdata;
            tx_sh    <= ctrl_byte(DEV_TYPE, cmd_dev_sel, RW_WRITE);
            rx_sh    <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            ack_nack <= 1'b0;
         end

         if (sample && state == RX_ACK) ack_nack <= sda_sync;
         if (sample && state == RX_BYTE) rx_sh <= {rx_sh[6:0], sda_sync};

         if (sym_end) begin
            case (state)
               TX_BYTE: begin
                  bit_cnt <= bit_cnt + 3'd1;
                  tx_sh   <= {tx_sh[6:0], 1'b0};
               end
               RX_BYTE: bit_cnt <= bit_cnt + 3'd1;
               RX_ACK: begin
                  byte_idx <= byte_idx + 2'd1;
                  // The read control byte is queued here; RSTART leaves tx_sh untouched
                  case (byte_idx)
                     2'd0:    tx_sh <= addr;
                     2'd1:    tx_sh <= is_read ? ctrl_byte(DEV_TYPE, dev_sel, RW_READ) : wdata;
                     default: ;
                  endcase
               end
               STOP: begin
                  rsp_nack  <= ack_nack;
                  rsp_rdata <= (is_read && !ack_nack) ? rx_sh : '0;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_eeprom_master.sv
// Scoreboarded bench for i2c_eeprom_master with a behavioural EEPROM on the bus.
`timescale 1ns/1ps
module tb_i2c_eeprom_master;
   import i2c_pkg::*;

   localparam int unsigned CLK_DIV = 4;
   localparam int SYM = 4 * CLK_DIV;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_read = 1'b0;
   logic [2:0] cmd_dev_sel = '0;
   logic [7:0] cmd_addr = '0;
   logic [7:0] cmd_wdata = '0;
   logic       cmd_ready, rsp_valid, rsp_nack, scl_oe, sda_oe;
   logic [7:0] rsp_rdata;
   logic       slave_pull = 1'b0;
   logic       sda_in;

   assign sda_in = ~(sda_oe | slave_pull);

   i2c_eeprom_master #(
      .CLK_DIV  (CLK_DIV),
      .DEV_TYPE (4'b1010)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_read    (cmd_read),
      .cmd_dev_sel (cmd_dev_sel),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_nack    (rsp_nack),
      .rsp_rdata   (rsp_rdata),
      .scl_oe      (scl_oe),
      .sda_oe      (sda_oe),
      .sda_in      (sda_in)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       nack;
      logic [7:0] rdata;
      int         lat;
      int         pulses;
      int         nbytes;
      logic [7:0] b[4];
      logic [3:0] acks;
   } exp_t;

   exp_t exp_q[$];
   int   acc_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;

   // EEPROM model configuration
   logic       slave_present = 1'b1;
   int         nack_byte = -1;
   logic [7:0] slave_rdata = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic exp_t mk(input logic nack, input logic [7:0] rdata, input int nsym,
                               input int pulses, input int nbytes,
                               input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3,
                               input logic [3:0] acks);
      exp_t e;
      e.nack   = nack;
      e.rdata  = rdata;
      e.lat    = nsym * SYM + 1;
      e.pulses = pulses;
      e.nbytes = nbytes;
      e.b[0]   = b0;
      e.b[1]   = b1;
      e.b[2]   = b2;
      e.b[3]   = b3;
      e.acks   = acks;
      return e;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Bus decoder, EEPROM model and response monitor share one process so that
   // the bus log is never cleared and appended in the same instant by two threads.
   initial begin
      logic       scl, sda, prev_scl, prev_sda, in_cond, cur_bit, lstop;
      logic [8:0] sh;
      logic [7:0] lb[$];
      logic       la[$];
      int         bits, lpulses;
      logic       sl_active, sl_tx, sl_acked;
      logic [7:0] sl_sh;
      int         sl_bit, sl_byte, a;
      exp_t       e;
      prev_scl = 1'b1; prev_sda = 1'b1; in_cond = 1'b0; cur_bit = 1'b1; lstop = 1'b0;
      sh = '0; bits = 0; lpulses = 0;
      sl_active = 1'b0; sl_tx = 1'b0; sl_acked = 1'b0; sl_sh = '0; sl_bit = 0; sl_byte = 0;
      forever begin
         @(negedge clk);
         scl = ~scl_oe;
         sda = sda_in;
         if (reset) begin
            lb.delete(); la.delete(); acc_q.delete();
            bits = 0; lpulses = 0; lstop = 1'b0; in_cond = 1'b0;
            sl_active = 1'b0; slave_pull = 1'b0;
         end else begin
            if (scl && prev_scl && (sda != prev_sda)) begin
               in_cond = 1'b1;
               if (!sda) begin
                  bits = 0; sl_active = 1'b1; sl_tx = 1'b0; sl_bit = 0; sl_byte = 0;
                  slave_pull = 1'b0;
               end else begin
                  lstop = 1'b1; sl_active = 1'b0; slave_pull = 1'b0;
               end
            end else if (scl && !prev_scl) begin
               in_cond = 1'b0;
               cur_bit = sda;
            end else if (!scl && prev_scl && !in_cond) begin
               lpulses++;
               sh = {sh[7:0], cur_bit};
               bits++;
               if (bits == 9) begin
                  lb.push_back(sh[8:1]);
                  la.push_back(sh[0]);
                  bits = 0;
               end
               if (sl_active) begin
                  if (!sl_tx) begin
                     if (sl_bit < 8) begin
                        sl_sh = {sl_sh[6:0], cur_bit};
                        sl_bit++;
                        if (sl_bit == 8) slave_pull = slave_present && (sl_byte != nack_byte);
                     end else begin
                        sl_acked = slave_pull;
                        slave_pull = 1'b0;
                        sl_bit = 0;
                        if (sl_acked && sl_byte == 0 && sl_sh[0]) begin
                           sl_tx = 1'b1;
                           slave_pull = ~slave_rdata[7];
                        end
                        sl_byte++;
                     end
                  end else begin
                     sl_bit++;
                     if (sl_bit < 8) slave_pull = ~slave_rdata[3'(7 - sl_bit)];
                     else slave_pull = 1'b0;
                     if (sl_bit == 9) sl_active = 1'b0;
                  end
               end
            end

            if (rsp_valid) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response (t=%0t)", $time);
               end else begin
                  e = exp_q.pop_front();
                  a = (acc_q.size() != 0) ? acc_q.pop_front() : -100000;
                  check("rsp_nack", 32'(rsp_nack), 32'(e.nack));
                  check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                  check("rsp_latency", 32'(cyc - a), 32'(e.lat));
                  check("scl_pulses", 32'(lpulses), 32'(e.pulses));
                  check("stop_seen", 32'(lstop), 32'd1);
                  check("byte_count", 32'(lb.size()), 32'(e.nbytes));
                  for (int i = 0; i < e.nbytes && i < lb.size(); i++) begin
                     check($sformatf("bus_byte%0d", i), 32'(lb[i]), 32'(e.b[i]));
                     check($sformatf("bus_ack%0d", i), 32'(la[i]), 32'(e.acks[i]));
                  end
               end
               lb.delete(); la.delete();
               lpulses = 0; lstop = 1'b0; bits = 0;
            end
            if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
         end
         prev_scl = scl;
         prev_sda = sda_in;
      end
   end

   task automatic issue(input logic rd, input logic [2:0] ds, input logic [7:0] ad, input logic [7:0] wd);
      logic ok;
      ok = 1'b0;
      cmd_read    = rd;
      cmd_dev_sel = ds;
      cmd_addr    = ad;
      cmd_wdata   = wd;
      cmd_valid   = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      check("cmd_accept", 32'(ok), 32'd1);
   endtask

   task automatic wait_rsp();
      for (int i = 0; i < 3000; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
      end
      check("rsp_pending", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic present, input int nb, input logic [7:0] rd);
      slave_present = present;
      nack_byte     = nb;
      slave_rdata   = rd;
   endtask

   initial begin
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_scl_oe", 32'(scl_oe), 32'd0);
      check("reset_sda_oe", 32'(sda_oe), 32'd0);
      check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_nack", 32'(rsp_nack), 32'd0);
      check("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Byte write, ACKing slave
      cfg(1'b1, -1, 8'h00);
      exp_q.push_back(mk(1'b0, 8'h00, WR_SYMBOLS, 27, 3, 8'hA0, 8'h05, 8'hA5, 8'h00, 4'b0000));
      issue(1'b0, 3'b000, 8'h05, 8'hA5);
      check("busy_cmd_ready", 32'(cmd_ready), 32'd0);
      wait_rsp();

      // Random read; master NACKs the received byte
      cfg(1'b1, -1, 8'h3C);
      exp_q.push_back(mk(1'b0, 8'h3C, RD_SYMBOLS, 36, 4, 8'hA6, 8'h7F, 8'hA7, 8'h3C, 4'b1000));
      issue(1'b1, 3'b011, 8'h7F, 8'h00);
      wait_rsp();
      repeat (5) @(posedge clk);
      #1;
      check("rdata_hold", 32'(rsp_rdata), 32'h3C);

      // No slave: NACK on the control byte, read data forced to zero
      cfg(1'b0, -1, 8'h00);
      exp_q.push_back(mk(1'b1, 8'h00, 11, 9, 1, 8'hA0, 8'h00, 8'h00, 8'h00, 4'b0001));
      issue(1'b1, 3'b000, 8'h10, 8'h00);
      wait_rsp();

      // Write-protected: slave NACKs the data byte
      cfg(1'b1, 2, 8'h00);
      exp_q.push_back(mk(1'b1, 8'h00, WR_SYMBOLS, 27, 3, 8'hA2, 8'h33, 8'h5A, 8'h00, 4'b0100));
      issue(1'b0, 3'b001, 8'h33, 8'h5A);
      wait_rsp();

      // Reset during the 4th address bit (symbol 13): bus released, no response
      cfg(1'b1, -1, 8'h00);
      issue(1'b0, 3'b000, 8'h44, 8'h11);
      repeat (13 * SYM + 5) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      check("abort_scl_oe", 32'(scl_oe), 32'd0);
      check("abort_sda_oe", 32'(sda_oe), 32'd0);
      check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
      check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      reset = 1'b0;
      repeat (3 * SYM) @(posedge clk);
      #1;

      // Second command held while busy, accepted in the rsp_valid cycle
      cfg(1'b1, -1, 8'h81);
      exp_q.push_back(mk(1'b0, 8'h00, WR_SYMBOLS, 27, 3, 8'hA4, 8'hC3, 8'h0F, 8'h00, 4'b0000));
      exp_q.push_back(mk(1'b0, 8'h81, RD_SYMBOLS, 36, 4, 8'hAE, 8'h00, 8'hAF, 8'h81, 4'b1000));
      issue(1'b0, 3'b010, 8'hC3, 8'h0F);
      issue(1'b1, 3'b111, 8'h00, 8'h00);
      check("b2b_cmd_ready", 32'(cmd_ready), 32'd0);
      wait_rsp();

      repeat (10) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      n_err++;
      $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
